// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: start/abort/enable/load/prescale in,
// count/busy/done/zero out.
interface countdown_timer_if #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
);
   logic             start;
   logic             abort;
   logic             en;
   logic [WIDTH-1:0] v;
   logic [PRE_W-1:0] div;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             zero;

   modport master (
      output start, abort, en, v, div,
      input  count, busy, done, zero
   );

   modport slave (
      input  start, abort, en, v, div,
      output count, busy, done, zero
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with one-cycle done pulse on expiry.
// Define COUNTDOWN_RELOAD_EN for periodic mode (reload from v at expiry); default is one-shot.
module countdown_timer #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   countdown_timer_if.slave      tmr
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [PRE_W-1:0] r_pre_cnt;
   logic [PRE_W-1:0] w_pre_nxt;
   logic             r_busy;
   logic             r_done;
   logic             w_done_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_pre_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_pre_cnt <= w_pre_nxt;
         r_busy    <= (w_state_nxt == S_RUN);
         r_done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_pre_nxt   = r_pre_cnt;
      w_done_nxt  = 1'b0;

      if (tmr.abort) begin
         w_state_nxt = S_IDLE;
         w_count_nxt = '0;
         w_pre_nxt   = '0;
      end else if (tmr.start) begin
         w_pre_nxt = '0;
         if (tmr.v != '0) begin
            w_count_nxt = tmr.v;
            w_state_nxt = S_RUN;
         end else begin
            w_count_nxt = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
      end else if (r_state == S_RUN && tmr.en) begin
         // A pre_cnt left above a newly lowered div wraps through zero before matching.
         if (r_pre_cnt != tmr.div) begin
            w_pre_nxt = r_pre_cnt + PRE_W'(1);
         end else begin
            w_pre_nxt = '0;
            if (r_count > WIDTH'(1)) begin
               w_count_nxt = r_count - WIDTH'(1);
            end else begin
               w_done_nxt = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
               if (tmr.v != '0) begin
                  w_count_nxt = tmr.v;
               end else begin
                  w_count_nxt = '0;
                  w_state_nxt = S_IDLE;
               end
`else
               w_count_nxt = '0;
               w_state_nxt = S_IDLE;
`endif
            end
         end
      end
   end

   assign tmr.count = r_count;
   assign tmr.busy  = r_busy;
   assign tmr.done  = r_done;
   assign tmr.zero  = (r_count == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a randomized run
// against a behavioural model; mode follows COUNTDOWN_RELOAD_EN.
module tb_countdown_timer;
   localparam int WIDTH = 8;
   localparam int PRE_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   // behavioural model state
   int m_count;
   int m_pre;
   bit m_run;
   bit m_done;

   always #5 clk = ~clk;

   countdown_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) tif ();

   countdown_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
      .clk (clk),
      .rst (rst),
      .tmr (tif)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s, input bit a, input bit e, input int vv, input int dd);
      tif.start = s;
      tif.abort = a;
      tif.en    = e;
      tif.v     = WIDTH'(vv);
      tif.div   = PRE_W'(dd);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      #12;
      total += 4;
      if (tif.count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", tif.count); end
      if (tif.busy  !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", tif.busy); end
      if (tif.done  !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", tif.done); end
      if (tif.zero  !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", tif.zero); end
      #3 rst = 1'b1;
      step();
   endtask

   task automatic test_one_shot();
      int ec[5] = '{3, 2, 1, 0, 0};
      bit eb[5] = '{1, 1, 1, 0, 0};
      bit ed[5] = '{0, 0, 0, 1, 0};
      drive(1, 0, 1, 3, 0);
      step();
      drive(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         total += 3;
         if (tif.count !== WIDTH'(ec[i])) begin bad++; $display("FAIL oneshot_count[%0d] got=%0d want=%0d", i, tif.count, ec[i]); end
         if (tif.busy !== eb[i]) begin bad++; $display("FAIL oneshot_busy[%0d] got=%b want=%b", i, tif.busy, eb[i]); end
         if (tif.done !== ed[i]) begin bad++; $display("FAIL oneshot_done[%0d] got=%b want=%b", i, tif.done, ed[i]); end
      end
   endtask

   task automatic test_prescale_pause();
      int ec[11] = '{2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 0};
      drive(1, 0, 1, 2, 2);
      step();
      for (int e = 0; e <= 10; e++) begin
         if (e > 0) begin
            drive(0, 0, (e >= 3 && e <= 6) ? 1'b0 : 1'b1, 0, 2);
            step();
         end
         total += 3;
         if (tif.count !== WIDTH'(ec[e])) begin bad++; $display("FAIL pause_count[%0d] got=%0d want=%0d", e, tif.count, ec[e]); end
         if (tif.done !== (e == 10)) begin bad++; $display("FAIL pause_done[%0d] got=%b want=%b", e, tif.done, e == 10); end
         if (tif.busy !== (e < 10)) begin bad++; $display("FAIL pause_busy[%0d] got=%b want=%b", e, tif.busy, e < 10); end
      end
   endtask

   task automatic test_abort_restart();
      drive(1, 0, 1, 4, 0);
      step();
      drive(0, 0, 1, 4, 0);
      step();
      drive(1, 1, 1, 4, 0);
      step();
      total += 3;
      if (tif.count !== 8'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", tif.count); end
      if (tif.busy  !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", tif.busy); end
      if (tif.done  !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", tif.done); end
      drive(0, 0, 1, 4, 0);
      step();
      total += 2;
      if (tif.count !== 8'd0) begin bad++; $display("FAIL abort_hold_count got=%0d want=0", tif.count); end
      if (tif.done  !== 1'b0) begin bad++; $display("FAIL abort_hold_done got=%b want=0", tif.done); end
      drive(1, 0, 1, 4, 0);
      step();
      drive(0, 0, 1, 4, 0);
      step();
      step();
      total += 1;
      if (tif.count !== 8'd2) begin bad++; $display("FAIL restart_pre_count got=%0d want=2", tif.count); end
      drive(1, 0, 1, 5, 0);
      step();
      total += 3;
      if (tif.count !== 8'd5) begin bad++; $display("FAIL restart_count got=%0d want=5", tif.count); end
      if (tif.busy  !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", tif.busy); end
      if (tif.done  !== 1'b0) begin bad++; $display("FAIL restart_done got=%b want=0", tif.done); end
      drive(0, 1, 1, 0, 0);
      step();
      drive(0, 0, 1, 0, 0);
   endtask

   task automatic test_zero_load();
      drive(1, 0, 1, 0, 0);
      step();
      total += 4;
      if (tif.done  !== 1'b1) begin bad++; $display("FAIL zload_done got=%b want=1", tif.done); end
      if (tif.busy  !== 1'b0) begin bad++; $display("FAIL zload_busy got=%b want=0", tif.busy); end
      if (tif.count !== 8'd0) begin bad++; $display("FAIL zload_count got=%0d want=0", tif.count); end
      if (tif.zero  !== 1'b1) begin bad++; $display("FAIL zload_zero got=%b want=1", tif.zero); end
      drive(0, 0, 1, 0, 0);
      step();
      total += 1;
      if (tif.done  !== 1'b0) begin bad++; $display("FAIL zload_done_clear got=%b want=0", tif.done); end
   endtask

   task automatic test_async_reset();
      drive(1, 0, 1, 7, 3);
      step();
      drive(0, 0, 1, 7, 3);
      total += 1;
      if (tif.count !== 8'd7) begin bad++; $display("FAIL areset_pre_count got=%0d want=7", tif.count); end
      #2 rst = 1'b0;
      #1;
      total += 3;
      if (tif.count !== 8'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", tif.count); end
      if (tif.busy  !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", tif.busy); end
      if (tif.done  !== 1'b0) begin bad++; $display("FAIL areset_done got=%b want=0", tif.done); end
      #1 rst = 1'b1;
      step();
      total += 1;
      if (tif.busy !== 1'b0) begin bad++; $display("FAIL areset_idle_busy got=%b want=0", tif.busy); end
      drive(1, 0, 1, 1, 0);
      step();
      drive(0, 0, 1, 0, 0);
      total += 2;
      if (tif.count !== 8'd1) begin bad++; $display("FAIL areset_resume_count got=%0d want=1", tif.count); end
      if (tif.busy  !== 1'b1) begin bad++; $display("FAIL areset_resume_busy got=%b want=1", tif.busy); end
      step();
      total += 2;
      if (tif.done  !== 1'b1) begin bad++; $display("FAIL areset_resume_done got=%b want=1", tif.done); end
      if (tif.count !== 8'd0) begin bad++; $display("FAIL areset_resume_end got=%0d want=0", tif.count); end
   endtask

   task automatic test_reload();
`ifdef COUNTDOWN_RELOAD_EN
      int ec[6] = '{2, 1, 2, 1, 2, 1};
      bit ed[6] = '{0, 0, 1, 0, 1, 0};
      bit eb[6] = '{1, 1, 1, 1, 1, 1};
`else
      int ec[6] = '{2, 1, 0, 0, 0, 0};
      bit ed[6] = '{0, 0, 1, 0, 0, 0};
      bit eb[6] = '{1, 1, 0, 0, 0, 0};
`endif
      drive(1, 0, 1, 2, 0);
      step();
      drive(0, 0, 1, 2, 0);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         total += 3;
         if (tif.count !== WIDTH'(ec[i])) begin bad++; $display("FAIL reload_count[%0d] got=%0d want=%0d", i, tif.count, ec[i]); end
         if (tif.done !== ed[i]) begin bad++; $display("FAIL reload_done[%0d] got=%b want=%b", i, tif.done, ed[i]); end
         if (tif.busy !== eb[i]) begin bad++; $display("FAIL reload_busy[%0d] got=%b want=%b", i, tif.busy, eb[i]); end
      end
      drive(0, 1, 1, 0, 0);
      step();
      drive(0, 0, 1, 0, 0);
   endtask

   // Next-edge expectation computed directly from the timer's rules.
   task automatic model_edge(input bit s, input bit a, input bit e, input int vv, input int dd);
      m_done = 1'b0;
      if (a) begin
         m_run = 1'b0; m_count = 0; m_pre = 0;
      end else if (s) begin
         m_pre = 0;
         if (vv != 0) begin m_count = vv; m_run = 1'b1; end
         else begin m_count = 0; m_done = 1'b1; m_run = 1'b0; end
      end else if (m_run && e) begin
         if (m_pre != dd) begin
            m_pre = (m_pre + 1) % (1 << PRE_W);
         end else begin
            m_pre = 0;
            if (m_count > 1) m_count = m_count - 1;
            else begin
               m_done = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
               if (vv != 0) m_count = vv;
               else begin m_count = 0; m_run = 1'b0; end
`else
               m_count = 0; m_run = 1'b0;
`endif
            end
         end
      end
   endtask

   task automatic test_random();
      bit s, a, e;
      int vv, dd;
      drive(0, 1, 0, 0, 0);
      step();
      m_count = 0; m_pre = 0; m_run = 1'b0; m_done = 1'b0;
      dd = 1;
      for (int n = 0; n < 3000; n++) begin
         s  = ($urandom % 20) == 0;
         a  = ($urandom % 60) == 0;
         e  = ($urandom % 5) != 0;
         vv = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 12));
         if (($urandom % 30) == 0) dd = int'($urandom_range(0, 15)) % ((($urandom % 3) == 0) ? 16 : 4);
         drive(s, a, e, vv, dd);
         model_edge(s, a, e, vv, dd);
         step();
         total += 4;
         if (tif.count !== WIDTH'(m_count)) begin bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", n, tif.count, m_count); end
         if (tif.busy !== m_run) begin bad++; $display("FAIL rand_busy[%0d] got=%b want=%b", n, tif.busy, m_run); end
         if (tif.done !== m_done) begin bad++; $display("FAIL rand_done[%0d] got=%b want=%b", n, tif.done, m_done); end
         if (tif.zero !== (m_count == 0)) begin bad++; $display("FAIL rand_zero[%0d] got=%b want=%b", n, tif.zero, m_count == 0); end
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_prescale_pause();
      test_abort_restart();
      test_zero_load();
      test_async_reset();
      test_reload();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
